// File: rtl/dla_platform_reset_pkg.sv
// Shared types for the platform reset sequencer: FSM state encoding,
// reset-count width and the saturating increment used for the count.
package dla_platform_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } reset_seq_state_t;

  localparam int RESET_COUNT_WIDTH = 8;

  function automatic logic [RESET_COUNT_WIDTH-1:0] sat_inc(
    input logic [RESET_COUNT_WIDTH-1:0] value
  );
    return (&value) ? value : value + RESET_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dla_platform_reset_lock_debounce.sv
// Counts consecutive cycles of PLL lock; o_lock_stable is high on the cycle
// whose edge completes LOCK_STABLE_CYCLES consecutive locked samples.
module dla_platform_reset_lock_debounce #(
  parameter int LOCK_STABLE_CYCLES = 256
) (
  input  logic clk,
  input  logic i_resetn,
  input  logic i_pll_locked,
  output logic o_lock_stable
);

  localparam int CW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_FULL = CW'(LOCK_STABLE_CYCLES);

  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!i_pll_locked) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_FULL) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Stable as soon as the current locked sample is the Nth in a row.
  assign o_lock_stable = i_pll_locked && (lock_cnt_q >= LOCK_LAST);

endmodule

// File: rtl/dla_platform_reset_sequencer.sv
// Platform reset sequencer: waits for stable PLL lock, holds the combined
// reset for a fixed width, releases it and confirms all domains are out.
//
//   state     | meaning
//   WAIT_LOCK | reset asserted, waiting for a stable lock run
//   HOLD      | reset asserted for exactly MIN_ASSERT_CYCLES
//   RELEASE   | reset released, waiting for every domain (or timeout)
//   RUN       | all domains out of reset, accepting software requests
module dla_platform_reset_sequencer
  import dla_platform_reset_pkg::*;
#(
  parameter int NUM_DOMAINS            = 2,
  parameter int LOCK_STABLE_CYCLES     = 256,
  parameter int MIN_ASSERT_CYCLES      = 16,
  parameter int RELEASE_TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         i_resetn,
  input  logic                         i_pll_locked,
  input  logic                         i_sw_reset_req,
  input  logic [NUM_DOMAINS-1:0]       i_domain_resetn,
  output logic                         o_resetn_combined,
  output logic                         o_reset_done,
  output logic                         o_release_timeout,
  output logic [RESET_COUNT_WIDTH-1:0] o_reset_count
);

  localparam int HOLD_W = $clog2(MIN_ASSERT_CYCLES + 1);
  localparam int TMO_W  = $clog2(RELEASE_TIMEOUT_CYCLES + 1);
  localparam int CNT_W  = (HOLD_W > TMO_W) ? HOLD_W : TMO_W;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(RELEASE_TIMEOUT_CYCLES - 1);

  reset_seq_state_t               state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           resetn_q, resetn_d;
  logic                           done_q, done_d;
  logic                           tmo_q, tmo_d;
  logic [RESET_COUNT_WIDTH-1:0]   count_q, count_d;
  logic                           lock_stable;
  logic                           domains_up;

  dla_platform_reset_lock_debounce #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_debounce (
    .clk          (clk),
    .i_resetn     (i_resetn),
    .i_pll_locked (i_pll_locked),
    .o_lock_stable(lock_stable)
  );

  assign domains_up = &i_domain_resetn;

  // cnt_q is a shared down-counter: hold width in HOLD, timeout in RELEASE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    count_d = count_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_stable) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          count_d = sat_inc(count_q);
        end
      end
      HOLD: begin
        if (!i_pll_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = TMO_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (!i_pll_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (domains_up) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        // Lock loss wins over a simultaneous software request.
        if (!i_pll_locked) begin
          state_d = WAIT_LOCK;
        end else if (i_sw_reset_req) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          tmo_d   = 1'b0;
          count_d = sat_inc(count_q);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    resetn_d = (state_d == RELEASE) || (state_d == RUN);
    done_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      resetn_q <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resetn_q <= resetn_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      count_q  <= count_d;
    end
  end

  assign o_resetn_combined = resetn_q;
  assign o_reset_done      = done_q;
  assign o_release_timeout = tmo_q;
  assign o_reset_count     = count_q;

endmodule
